// File: rtl/msg_pkg.sv
// ---------------------------------------------------------------------------
// msg_pkg -- shared definitions for the UART/cell message buffer.
//
// Contents:
//   ADDR_WIDTH   width of one cell coordinate field minus one
//   MSG_WIDTH    packed message width, 2*(ADDR_WIDTH+1)+4 = 14
//   msg_t        packed message {i, j, status}
//   STATUS_IDLE  status code carried when a cell has nothing to report
//   wr_state_t / rd_state_t / queue_dbg_t
//                handshake states of msg_queue, exported through the
//                debug field of msg_queue_if
// ---------------------------------------------------------------------------
package msg_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int MSG_WIDTH  = 2 * (ADDR_WIDTH + 1) + 4;

    typedef struct packed {
        logic [ADDR_WIDTH:0] i;
        logic [ADDR_WIDTH:0] j;
        logic [3:0]          status;
    } msg_t;

    localparam logic [3:0] STATUS_IDLE = 4'hF;

    // Producer side: WR_ACK means write_ack is high and the current
    // write_en phase has already been consumed.
    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_ACK  = 1'b1
    } wr_state_t;

    // Consumer side: RD_DONE means the head was popped for the current
    // read_ack phase; nothing more is offered until read_ack goes low.
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DONE = 1'b1
    } rd_state_t;

    typedef struct packed {
        wr_state_t wr;
        rd_state_t rd;
    } queue_dbg_t;

endpackage

// File: rtl/msg_queue_if.sv
// ---------------------------------------------------------------------------
// msg_queue_if -- producer and consumer handshake bundle of msg_queue.
//
// Handshake (both sides are level-based 4-phase):
//   producer: raise write_en with write valid, wait for write_ack=1, drop
//             write_en, wait for write_ack=0. One message per write_en phase.
//   consumer: when read_en=1 the head is on read; raise read_ack, see
//             read_en drop, drop read_ack. One message per read_ack phase.
//
// Signals:
//   write     [WIDTH]  message to enqueue        (producer -> queue)
//   write_en           producer request          (producer -> queue)
//   write_ack          push acknowledge          (queue -> producer)
//   read      [WIDTH]  head message              (queue -> consumer)
//   read_en            head available            (queue -> consumer)
//   read_ack           consumer done with head   (consumer -> queue)
//   dbg                handshake state snapshot  (queue -> observers)
//
// Modports: master = producer/consumer environment, slave = the queue.
// ---------------------------------------------------------------------------
interface msg_queue_if #(
    parameter int WIDTH = 14
);
    import msg_pkg::*;

    logic [WIDTH-1:0] write;
    logic             write_en;
    logic             write_ack;
    logic [WIDTH-1:0] read;
    logic             read_en;
    logic             read_ack;
    queue_dbg_t       dbg;

    modport master (
        output write, write_en, read_ack,
        input  write_ack, read, read_en, dbg
    );

    modport slave (
        input  write, write_en, read_ack,
        output write_ack, read, read_en, dbg
    );

endinterface

// File: rtl/msg_queue_mem.sv
// ---------------------------------------------------------------------------
// msg_queue_mem -- DEPTH x WIDTH register file, one write port, one
// asynchronous read port. Contents are not reset.
//
// Ports:
//   i_clk    clock, write on posedge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, combinational from i_raddr
// ---------------------------------------------------------------------------
module msg_queue_mem #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/msg_queue.sv
// ---------------------------------------------------------------------------
// msg_queue -- synchronous FIFO of fixed-width messages with 4-phase
// request/acknowledge handshakes on both the producer and consumer side.
//
// Ports:
//   clk     system clock, all logic on posedge
//   reset   synchronous, active-high reset
//   bus     msg_queue_if.slave (write/write_en/write_ack,
//           read/read_en/read_ack, dbg)
//   full, empty, count
//           occupancy status, present only when QUEUE_STATUS_EN is defined
//
// Optional feature macro: QUEUE_STATUS_EN.
// ---------------------------------------------------------------------------
module msg_queue
    import msg_pkg::*;
#(
    parameter int WIDTH = MSG_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    msg_queue_if.slave       bus
`ifdef QUEUE_STATUS_EN
    ,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    wr_state_t        r_wr_state;
    wr_state_t        w_wr_next;
    rd_state_t        r_rd_state;
    rd_state_t        w_rd_next;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_mem_rdata;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A pop frees a slot in the same cycle, so a pending push into a full
    // queue lands together with the pop. When full, head == tail: the
    // popped entry is overwritten at the edge, after it was consumed.
    assign w_pop  = bus.read_ack && (r_rd_state == RD_IDLE) && !w_empty;
    assign w_push = bus.write_en && (r_wr_state == WR_IDLE) && (!w_full || w_pop);

    msg_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (bus.write),
        .i_raddr (r_head),
        .o_rdata (w_mem_rdata)
    );

    // Next-state logic for both handshakes and the occupancy count.
    always_comb begin
        w_wr_next    = r_wr_state;
        w_rd_next    = r_rd_state;
        w_count_next = r_count;

        case (r_wr_state)
            WR_IDLE: if (w_push)        w_wr_next = WR_ACK;
            WR_ACK:  if (!bus.write_en) w_wr_next = WR_IDLE;
            default:                    w_wr_next = WR_IDLE;
        endcase

        case (r_rd_state)
            RD_IDLE: if (w_pop)         w_rd_next = RD_DONE;
            RD_DONE: if (!bus.read_ack) w_rd_next = RD_IDLE;
            default:                    w_rd_next = RD_IDLE;
        endcase

        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
            r_count    <= w_count_next;
            // DEPTH is a power of two, so the natural wrap is modulo DEPTH.
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
        end
    end

    assign bus.write_ack = (r_wr_state == WR_ACK);
    assign bus.read_en   = !w_empty && (r_rd_state == RD_IDLE);
    assign bus.read      = w_empty ? '0 : w_mem_rdata;
    assign bus.dbg       = '{wr: r_wr_state, rd: r_rd_state};

`ifdef QUEUE_STATUS_EN
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;
`endif

endmodule

// File: tb/tb_msg_queue.sv
// ---------------------------------------------------------------------------
// tb_msg_queue -- self-checking bench for msg_queue (WIDTH=14, DEPTH=4).
// A queue-based reference model advances on each posedge; a compare process
// checks every DUT output against it on each negedge. Directed sequences
// add literal expectations, then randomized handshakes run against the model.
// Optional status ports are checked when QUEUE_STATUS_EN is defined.
// ---------------------------------------------------------------------------
module tb_msg_queue;
    import msg_pkg::*;

    localparam int W     = MSG_WIDTH;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    msg_queue_if #(.WIDTH(W)) bus ();

`ifdef QUEUE_STATUS_EN
    logic       full;
    logic       empty;
    logic [2:0] count;
`endif

    msg_queue #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef QUEUE_STATUS_EN
        ,
        .full  (full),
        .empty (empty),
        .count (count)
`endif
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard counters and check helper
    // ------------------------------------------------------------------
    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of messages plus the two handshake flags,
    // updated from the inputs present at each rising edge.
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    bit           m_ack;
    bit           m_rd_done;
    bit           model_valid = 1'b0;
    bit           m_push;
    bit           m_pop;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_ack       = 1'b0;
            m_rd_done   = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_pop  = bus.read_ack && !m_rd_done && (exp_q.size() > 0);
            m_push = bus.write_en && !m_ack && ((exp_q.size() < DEPTH) || m_pop);
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(bus.write);
            if (m_push)            m_ack = 1'b1;
            else if (!bus.write_en) m_ack = 1'b0;
            if (m_pop)             m_rd_done = 1'b1;
            else if (!bus.read_ack) m_rd_done = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every negedge once the model has seen a reset.
    // ------------------------------------------------------------------
    logic         exp_ren;
    logic [W-1:0] exp_rd;

    always @(negedge clk) begin
        if (model_valid) begin
            exp_ren = (exp_q.size() > 0) && !m_rd_done;
            exp_rd  = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("write_ack", 32'(bus.write_ack), 32'(m_ack));
            check("read_en",   32'(bus.read_en),   32'(exp_ren));
            check("read",      32'(bus.read),      32'(exp_rd));
`ifdef QUEUE_STATUS_EN
            check("count", 32'(count), 32'(exp_q.size()));
            check("full",  32'(full),  32'(exp_q.size() == DEPTH));
            check("empty", 32'(empty), 32'(exp_q.size() == 0));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        bus.write_en = 1'b0;
        bus.read_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_hs(input logic [W-1:0] data);
        int n;
        bus.write    = data;
        bus.write_en = 1'b1;
        n = 0;
        while (!bus.write_ack && n < 40) begin
            tick();
            n++;
        end
        if (!bus.write_ack) begin
            miscompares++;
            $display("FAIL push_timeout: write_ack=0 after %0d cycles, expected 1", n);
        end
        bus.write_en = 1'b0;
        n = 0;
        while (bus.write_ack && n < 40) begin
            tick();
            n++;
        end
        if (bus.write_ack) begin
            miscompares++;
            $display("FAIL push_release_timeout: write_ack=1, expected 0");
        end
    endtask

    task automatic pop_hs(output logic [W-1:0] data);
        int n;
        n = 0;
        while (!bus.read_en && n < 40) begin
            tick();
            n++;
        end
        if (!bus.read_en) begin
            miscompares++;
            $display("FAIL pop_timeout: read_en=0 after %0d cycles, expected 1", n);
        end
        data = bus.read;
        bus.read_ack = 1'b1;
        tick();
        bus.read_ack = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [W-1:0] got;
    msg_t         m;

    initial begin
        reset        = 1'b1;
        bus.write    = '0;
        bus.write_en = 1'b0;
        bus.read_ack = 1'b0;

        // Reset state
        apply_reset();
        check("rst_read_en",   32'(bus.read_en),   32'd0);
        check("rst_write_ack", 32'(bus.write_ack), 32'd0);

        // Single push: ack and data one cycle later
        bus.write    = 14'h1234;
        bus.write_en = 1'b1;
        tick();
        check("t1_write_ack", 32'(bus.write_ack), 32'd1);
        check("t1_read_en",   32'(bus.read_en),   32'd1);
        check("t1_read",      32'(bus.read),      32'h1234);
        bus.write_en = 1'b0;
        tick();
        check("t1_ack_fall", 32'(bus.write_ack), 32'd0);
        pop_hs(got);
        check("t1_pop", 32'(got), 32'h1234);
        check("t1_empty_after_pop", 32'(bus.read_en), 32'd0);

        // Long write_en phase: exactly one push
        bus.write    = 14'h0ABC;
        bus.write_en = 1'b1;
        repeat (10) tick();
        check("t2_ack_held",   32'(bus.write_ack), 32'd1);
        check("t2_model_size", 32'(exp_q.size()),  32'd1);
        bus.write_en = 1'b0;
        check("t2_ack_before_fall", 32'(bus.write_ack), 32'd1);
        tick();
        check("t2_ack_fall", 32'(bus.write_ack), 32'd0);
        pop_hs(got);
        check("t2_pop", 32'(got), 32'h0ABC);
        check("t2_drained", 32'(bus.read_en), 32'd0);

        // Fill, stall a 5th push, then pop and push in the same cycle
        for (int k = 1; k <= 4; k++) push_hs(W'(k));
        check("t3_model_full", 32'(exp_q.size()), 32'd4);
        bus.write    = 14'h0005;
        bus.write_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_ack_while_full", 32'(bus.write_ack), 32'd0);
        end
        check("t3_head", 32'(bus.read), 32'h0001);
        bus.read_ack = 1'b1;
        tick();
        check("t3_simul_ack",  32'(bus.write_ack), 32'd1);
        check("t3_simul_size", 32'(exp_q.size()),  32'd4);
        check("t3_simul_ren",  32'(bus.read_en),   32'd0);
        bus.read_ack = 1'b0;
        bus.write_en = 1'b0;
        tick();
        for (int k = 2; k <= 5; k++) begin
            pop_hs(got);
            check("t3_order", 32'(got), 32'(k));
        end

        // read_ack held high: exactly one pop
        push_hs(14'h0011);
        push_hs(14'h0022);
        bus.read_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_ren_held_low", 32'(bus.read_en), 32'd0);
        end
        bus.read_ack = 1'b0;
        tick();
        check("t4_ren_back", 32'(bus.read_en), 32'd1);
        check("t4_second",   32'(bus.read),    32'h0022);
        pop_hs(got);

        // Reset in the middle of a write handshake
        push_hs(14'h0031);
        bus.write    = 14'h0032;
        bus.write_en = 1'b1;
        tick();
        check("t5_ack_mid",   32'(bus.write_ack), 32'd1);
        check("t5_model_two", 32'(exp_q.size()),  32'd2);
        reset        = 1'b1;
        bus.write_en = 1'b0;
        tick();
        check("t5_rst_ren", 32'(bus.read_en),   32'd0);
        check("t5_rst_ack", 32'(bus.write_ack), 32'd0);
        reset = 1'b0;
        m = '{i: 5'd3, j: 5'd7, status: STATUS_IDLE};
        push_hs(W'(m));
        check("t5_after_rst", 32'(bus.read), 32'(W'(m)));
        pop_hs(got);

        // Randomized handshakes against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                if (!bus.write_en) bus.write = W'($urandom);
                bus.write_en = !bus.write_en;
            end
            if ($urandom_range(0, (c < 1500) ? 7 : 2) == 0) begin
                bus.read_ack = !bus.read_ack;
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
